// File: rtl/store_rmw_pkg.sv
// Shared CPU package: load-extension and store-op encodings, plus the
// read-modify-write store FSM state encoding and small decode helpers.
package store_rmw_pkg;

    typedef enum logic [2:0] {
        EXT_LW  = 3'd0,
        EXT_LH  = 3'd1,
        EXT_LHU = 3'd2,
        EXT_LB  = 3'd3,
        EXT_LBU = 3'd4
    } ext_op_e;

    typedef enum logic [1:0] {
        STORE_SW     = 2'b00,
        STORE_SH     = 2'b01,
        STORE_SB     = 2'b10,
        STORE_SW_ALT = 2'b11
    } store_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } store_state_e;

    // 2'b11 is an undefined encoding that behaves exactly like a word store
    function automatic logic is_word_op(input store_op_e op);
        return (op == STORE_SW) || (op == STORE_SW_ALT);
    endfunction

    function automatic logic is_misaligned(input store_op_e op, input logic [1:0] lane);
        logic mis;
        case (op)
            STORE_SH: mis = lane[0];
            STORE_SB: mis = 1'b0;
            default:  mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_rmw_if.sv
// Store request + data-memory bus bundle; master drives requests and read
// data, slave is the store_rmw engine.
interface store_rmw_if;
    logic        req;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  StoreOp;
    logic [29:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        done;
    logic        align_err;

    modport master (
        output req, addr, wdata, StoreOp, mem_rdata,
        input  ready, mem_addr, mem_re, mem_we, mem_wdata, done, align_err
    );

    modport slave (
        input  req, addr, wdata, StoreOp, mem_rdata,
        output ready, mem_addr, mem_re, mem_we, mem_wdata, done, align_err
    );
endinterface

// File: rtl/store_merge.sv
// Little-endian lane merge: inserts the store byte/half/word into the old
// memory word, keeping all untouched lanes.
module store_merge
    import store_rmw_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    input  store_op_e   i_op,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_word
);

    logic [31:0] w_src;
    logic [3:0]  w_be;

    // Replicate the store data so every lane sees its candidate byte
    always_comb begin
        w_src = i_wdata;
        case (i_op)
            STORE_SH: w_src = {2{i_wdata[15:0]}};
            STORE_SB: w_src = {4{i_wdata[7:0]}};
            default:  w_src = i_wdata;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign w_be[gi] = (i_op == STORE_SH) ? (i_lane[1] == LANE[1]) :
                              (i_op == STORE_SB) ? (i_lane == LANE) : 1'b1;
            assign o_word[8*gi +: 8] = w_be[gi] ? w_src[8*gi +: 8] : i_old[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/store_rmw.sv
// Store engine: word stores go straight to memory, byte/half stores do a
// read-modify-write of the containing word; misaligned stores pulse align_err.
module store_rmw
    import store_rmw_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    store_rmw_if.slave   bus
);

    store_state_e r_state;
    store_state_e w_state_next;
    logic [31:0]  r_addr;
    logic [31:0]  r_wdata;
    logic [31:0]  r_rdata;
    store_op_e    r_op;
    store_op_e    w_req_op;
    logic         w_accept;
    logic         w_write;
    logic [31:0]  w_merged;

    assign w_req_op = store_op_e'(bus.StoreOp);
    assign w_accept = (r_state == ST_IDLE) && bus.req;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    if (is_misaligned(w_req_op, bus.addr[1:0]))
                        w_state_next = ST_ERR;
                    else if (is_word_op(w_req_op))
                        w_state_next = ST_WRITE;
                    else
                        w_state_next = ST_READ;
                end
            end
            ST_READ:  w_state_next = ST_MERGE;
            ST_MERGE: w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = ST_IDLE;
            ST_ERR:   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Request fields are frozen from acceptance until the FSM returns to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= STORE_SW;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
                r_op    <= w_req_op;
            end
            if (r_state == ST_MERGE)
                r_rdata <= bus.mem_rdata;
        end
    end

    store_merge u_merge (
        .i_old   (r_rdata),
        .i_wdata (r_wdata),
        .i_op    (r_op),
        .i_lane  (r_addr[1:0]),
        .o_word  (w_merged)
    );

    // A reset landing on the WRITE cycle suppresses the write itself
    assign w_write       = (r_state == ST_WRITE) && !reset;
    assign bus.ready     = (r_state == ST_IDLE);
    assign bus.mem_re    = (r_state == ST_READ);
    assign bus.mem_we    = w_write;
    assign bus.done      = w_write;
    assign bus.mem_wdata = w_write ? w_merged : 32'h0;
    assign bus.align_err = (r_state == ST_ERR);
    assign bus.mem_addr  = r_addr[31:2];

endmodule

// File: doc/store_rmw.md
STORE_RMW -- requirements
Module: store_rmw

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: req  input  1  store request; sampled only when ready=1.
REQ-004 SHALL have port: ready  output  1  high iff FSM in IDLE.
REQ-005 SHALL have port: addr  input  32  byte address of store.
REQ-006 SHALL have port: wdata  input  32  store data; low byte/half used for sb/sh.
REQ-007 SHALL have port: StoreOp  input  2  00=sw, 01=sh, 10=sb, 11=treated as sw.
REQ-008 SHALL have port: mem_addr  output  30  word address to data memory (addr[31:2] of accepted request).
REQ-009 SHALL have port: mem_re  output  1  word read strobe; memory returns mem_rdata on the next cycle.
REQ-010 SHALL have port: mem_rdata  input  32  read data, valid the cycle after mem_re.
REQ-011 SHALL have port: mem_we  output  1  full-word write strobe.
REQ-012 SHALL have port: mem_wdata  output  32  word written when mem_we=1.
REQ-013 SHALL have port: done  output  1  one-cycle pulse coincident with the completing mem_we.
REQ-014 SHALL have port: align_err  output  1  one-cycle pulse on misaligned request; no memory access.

Function
REQ-015 SHALL implement states IDLE, READ, MERGE, WRITE, ERR.
REQ-016 SHALL, on req=1 in IDLE, register addr, wdata, StoreOp in the same edge; fields are then held stable until return to IDLE.
REQ-017 SHALL treat misalignment as: sw/11 with addr[1:0]!=0, or sh with addr[0]=1; transition IDLE->ERR, ERR->IDLE, align_err=1 in ERR only.
REQ-018 SHALL for aligned sw transition IDLE->WRITE; mem_wdata=wdata; done and mem_we one cycle after acceptance.
REQ-019 SHALL for aligned sh/sb transition IDLE->READ->MERGE->WRITE->IDLE; mem_re=1 in READ only; mem_rdata captured at end of MERGE; mem_we=1 and done=1 in WRITE (3 cycles after acceptance).
REQ-020 SHALL merge little-endian: sb replaces bits [8k+7:8k], k=addr[1:0], with wdata[7:0]; sh replaces [31:16] if addr[1]=1 else [15:0] with wdata[15:0]; other bits from captured read word.
REQ-021 SHALL hold mem_addr constant from READ through WRITE; mem_re and mem_we SHALL never be high in the same cycle.
REQ-022 SHALL ignore req while ready=0 (not queued); req in the WRITE or ERR cycle is not accepted until IDLE.
REQ-023 SHALL allow back-to-back requests: a req sampled in IDLE the cycle after WRITE is accepted normally.
REQ-024 SHALL keep mem_wdata=0 when mem_we=0.

Reset
REQ-025 SHALL on reset=1 force state IDLE, ready=1, mem_re=0, mem_we=0, done=0, align_err=0, mem_addr=0, mem_wdata=0, capture registers=0.
REQ-026 SHALL abort any in-flight operation on reset: no mem_we issued for it, even if reset coincides with the WRITE cycle of the next edge.
REQ-027 SHALL ignore req in any cycle where reset=1.

Structure
REQ-028 SHALL place StoreOp encodings and FSM state encodings in the shared CPU package alongside the existing ExtOp encodings.
REQ-029 SHALL implement lane merging (REQ-020) in one combinational sub-module, store_merge (inputs: old word, wdata, StoreOp, addr[1:0]; output: merged word).
REQ-030 SHALL implement FSM and capture registers in store_rmw only.

Verification
REQ-031 SHALL test sw: addr=0x100, wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF, done=1 one cycle after accept; mem_re never high.
REQ-032 SHALL test sb: addr=0x103, wdata=0x000000AA, mem_rdata=0x11223344 -> mem_re at accept+1, mem_wdata=0xAA223344 with done at accept+3.
REQ-033 SHALL test sh: addr=0x102, wdata=0x0000BEEF, mem_rdata=0x11223344 -> mem_wdata=0xBEEF3344; addr=0x100 -> 0x1122BEEF.
REQ-034 SHALL test misalign: sh at 0x101 and sw at 0x102 -> align_err pulse at accept+1, no mem_re/mem_we/done, ready=1 at accept+2.
REQ-035 SHALL test reset mid-op: sb accepted, reset=1 in MERGE cycle -> no mem_we ever, all outputs at reset values next cycle.
REQ-036 SHALL test busy/back-to-back: req held high across an sb -> exactly one accept, second accepted the cycle after WRITE, two done pulses total.
